mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- WAIT_CYCLES, 2, external memory wait states (0..15 legal)
- IO_ADDR, 16'hFFFF, single memory-mapped I/O address
- LED_W, 10, LED register width (LED_W <= DATA_W)

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clk, in, 1, sole clock; all state updates on rising edge
- Reset, in, 1, synchronous, active-high
- req_valid, in, 1, CPU access request
- req_ready, out, 1, unit can accept a request
- req_we, in, 1, 1 = write, 0 = read
- req_addr, in, ADDR_W, access address
- req_wdata, in, DATA_W, write data
- resp_valid, out, 1, one-cycle completion pulse
- resp_rdata, out, DATA_W, read data, valid with resp_valid
- MAR, out, ADDR_W, address register
- MDR, out, DATA_W, data register
- mem_addr, out, ADDR_W, external address (= MAR)
- mem_wdata, out, DATA_W, external write data (= MDR)
- mem_rdata, in, DATA_W, external read data
- mem_oe, out, 1, external read strobe, active-high
- mem_we, out, 1, external write strobe, active-high
- SW, in, DATA_W, switch inputs, readable at IO_ADDR
- LED, out, LED_W, LED register, writable at IO_ADDR

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, IO, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid & req_ready.
REQ-005 On acceptance, MAR SHALL load req_addr, and on writes MDR SHALL load req_wdata, at that same edge.
REQ-006 Acceptance SHALL enter IO if req_addr == IO_ADDR, else ACCESS with wait counter cleared to 0.
REQ-007 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles; mem_oe (read) or mem_we (write) SHALL be 1 throughout it and 0 in every other state.
REQ-008 On the final ACCESS cycle of a read, MDR SHALL capture mem_rdata; the next state SHALL be RESP.
REQ-009 IO SHALL last 1 cycle with no external strobe; a read SHALL load MDR with SW; a write SHALL load LED with MDR[LED_W-1:0]; the next state SHALL be RESP.
REQ-010 RESP SHALL last 1 cycle with resp_valid = 1 and resp_rdata = MDR, then return to IDLE; resp_rdata SHALL hold MDR in all states.
REQ-011 Latency SHALL be fixed: resp_valid asserts WAIT_CYCLES+2 cycles after the accepting edge for memory accesses, 2 cycles for IO.
REQ-012 req_valid while not IDLE SHALL be ignored without side effects; no request is queued.
REQ-013 The wait counter SHALL be $clog2(WAIT_CYCLES+1) bits minimum (>=1) and SHALL not wrap within one access; WAIT_CYCLES = 0 SHALL give a single-cycle ACCESS.
REQ-014 LED SHALL change only on an IO write; memory writes SHALL never alter LED.
REQ-015 Back-to-back: a request may be accepted in the cycle immediately after RESP (IDLE), giving a throughput of one access per WAIT_CYCLES+3 cycles.

Reset
REQ-016 Reset SHALL force state IDLE and clear MAR, MDR, LED and the wait counter to 0, giving mem_oe = mem_we = resp_valid = 0 and req_ready = 1 after the edge.
REQ-017 Reset asserted mid-ACCESS or mid-IO SHALL abort the access at that edge, with no MDR capture, no LED update and no resp_valid.
REQ-018 Reset SHALL take priority over a simultaneous request.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and the default IO_ADDR constant.
REQ-020 MAR, MDR and LED SHALL use the existing parametrised load-enable register sub-module (register, parameter N); the FSM and wait counter SHALL be local.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Read 0x0040 (WAIT_CYCLES=2, mem_rdata=0xBEEF) -> mem_oe high 3 cycles; resp_valid 4 cycles after accept; resp_rdata = 0xBEEF.
- Write 0x0041 with 0x1234 -> mem_we high 3 cycles; mem_addr = 0x0041; mem_wdata = 0x1234; LED unchanged.
- IO write 0xFFFF with 0x03FF -> no strobes; LED = 0x3FF; resp_valid at cycle 2. Then IO read with SW = 0x00A5 -> resp_rdata = 0x00A5.
- req_valid held high through a read -> exactly one access; second request accepted in the IDLE cycle after RESP.
- Reset at the 2nd ACCESS cycle of a read -> next cycle is IDLE; MDR = 0; no resp_valid; strobes low.
- WAIT_CYCLES=0 instance read -> mem_oe 1 cycle; resp_valid 2 cycles after accept.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the CPU-side memory access unit.
package mem_access_unit_pkg;

  // Sequencer states: wait for a request, drive external memory, do the
  // single I/O register access, then present the response for one cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_IO     = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Default location of the memory-mapped switch/LED port.
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit_register.sv
// Parametrised load-enable register with synchronous active-high clear.
module register #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;

  // Hold the current value unless a load is requested.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Storage; a clear wins over a load on the same edge.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesised netlist.
    if (Reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : register

// File: rtl/mem_access_unit.sv
// CPU memory access unit: accepts one read/write request at a time, runs a
// fixed-wait external memory cycle or a single-cycle I/O access (switches in,
// LEDs out), and returns a one-cycle response pulse with the MDR contents.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT),
  parameter int                LED_W       = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] SW,
  output logic [LED_W-1:0]  LED
);

  // Wait counter is wide enough to reach WAIT_CYCLES and never narrower
  // than one bit, so a zero-wait build still has a legal counter.
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             we_d, we_q;

  logic              mar_load;
  logic [ADDR_W-1:0] mar_d;
  logic              mdr_load;
  logic [DATA_W-1:0] mdr_d;
  logic              led_load;
  logic [LED_W-1:0]  led_d;

  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [LED_W-1:0]  led_q;

  // Next-state, register load controls and strobes for the access sequence.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // forgot one would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    mar_load   = 1'b0;
    mar_d      = req_addr;
    mdr_load   = 1'b0;
    mdr_d      = req_wdata;
    led_load   = 1'b0;
    led_d      = mdr_q[LED_W-1:0];
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mar_load = 1'b1;
          we_d     = req_we;
          mdr_load = req_we;
          if (req_addr == IO_ADDR) begin
            state_d = ST_IO;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
          end
        end
      end

      ST_ACCESS: begin
        mem_oe = ~we_q;
        mem_we = we_q;
        if (cnt_q == CNT_LAST) begin
          // Read data is only trusted on the last wait state.
          mdr_load = ~we_q;
          mdr_d    = mem_rdata;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IO: begin
        led_load = we_q;
        mdr_load = ~we_q;
        mdr_d    = SW;
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, wait counter and latched direction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  register #(.N(ADDR_W)) u_mar (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (mar_load),
    .d     (mar_d),
    .q     (mar_q)
  );

  register #(.N(DATA_W)) u_mdr (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (mdr_load),
    .d     (mdr_d),
    .q     (mdr_q)
  );

  register #(.N(LED_W)) u_led (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (led_load),
    .d     (led_d),
    .q     (led_q)
  );

  assign MAR        = mar_q;
  assign MDR        = mdr_q;
  assign LED        = led_q;
  assign mem_addr   = mar_q;
  assign mem_wdata  = mdr_q;
  assign resp_rdata = mdr_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic
// against a transaction-level model, with a zero-wait instance on the side.
module tb_mem_access_unit;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata, MAR, MDR, mem_addr, mem_wdata, mem_rdata, SW;
  logic        mem_oe, mem_we;
  logic [9:0]  LED;

  logic        r0_reset;
  logic        r0_req_valid, r0_req_ready, r0_req_we;
  logic [15:0] r0_req_addr, r0_req_wdata;
  logic        r0_resp_valid;
  logic [15:0] r0_resp_rdata, r0_mar, r0_mdr, r0_mem_addr, r0_mem_wdata, r0_mem_rdata, r0_sw;
  logic        r0_mem_oe, r0_mem_we;
  logic [9:0]  r0_led;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level view of the architectural registers.
  logic [15:0] m_mdr;
  logic [9:0]  m_led;

  always #5 Clk = ~Clk;

  mem_access_unit #(
    .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(W), .IO_ADDR(16'hFFFF), .LED_W(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .MAR(MAR), .MDR(MDR),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .SW(SW), .LED(LED)
  );

  mem_access_unit #(
    .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0), .IO_ADDR(16'hFFFF), .LED_W(10)
  ) dut0 (
    .Clk(Clk), .Reset(r0_reset), .req_valid(r0_req_valid), .req_ready(r0_req_ready),
    .req_we(r0_req_we), .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
    .resp_valid(r0_resp_valid), .resp_rdata(r0_resp_rdata), .MAR(r0_mar), .MDR(r0_mdr),
    .mem_addr(r0_mem_addr), .mem_wdata(r0_mem_wdata), .mem_rdata(r0_mem_rdata),
    .mem_oe(r0_mem_oe), .mem_we(r0_mem_we), .SW(r0_sw), .LED(r0_led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic accept(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit hold);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  // Follow an accepted request to its response and compare with the model.
  // Returns while the unit is in its response cycle.
  task automatic complete(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] mrd, input logic [15:0] sw, input string tag);
    bit          is_io;
    int          lat, oe_n, we_n, resp_n;
    bit          got_strobe;
    logic [15:0] resp_d, s_addr, s_wdata;
    is_io      = (addr == 16'hFFFF);
    lat        = is_io ? 2 : W + 2;
    mem_rdata  = mrd;
    SW         = sw;
    oe_n       = 0;
    we_n       = 0;
    resp_n     = 0;
    got_strobe = 1'b0;
    resp_d     = 'x;
    s_addr     = 'x;
    s_wdata    = 'x;
    if (is_io) begin
      if (we) begin
        m_led = wdata[9:0];
        m_mdr = wdata;
      end else begin
        m_mdr = sw;
      end
    end else begin
      m_mdr = we ? wdata : mrd;
    end
    for (int n = 1; n <= lat + 3 && resp_n == 0; n++) begin
      if (n > 1) step();
      oe_n += int'(mem_oe);
      we_n += int'(mem_we);
      if ((mem_oe || mem_we) && !got_strobe) begin
        got_strobe = 1'b1;
        s_addr     = mem_addr;
        s_wdata    = mem_wdata;
      end
      if (resp_valid) begin
        resp_n = n;
        resp_d = resp_rdata;
      end
    end
    check({tag, "/latency"}, resp_n, lat);
    check({tag, "/oe_cycles"}, oe_n, (!we && !is_io) ? W + 1 : 0);
    check({tag, "/we_cycles"}, we_n, (we && !is_io) ? W + 1 : 0);
    check({tag, "/resp_rdata"}, resp_d, m_mdr);
    check({tag, "/MDR"}, MDR, m_mdr);
    check({tag, "/MAR"}, MAR, addr);
    check({tag, "/LED"}, LED, m_led);
    if (!is_io) check({tag, "/mem_addr"}, s_addr, addr);
    if (we && !is_io) check({tag, "/mem_wdata"}, s_wdata, wdata);
  endtask

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] mrd, input logic [15:0] sw, input string tag);
    check({tag, "/ready"}, req_ready, 1'b1);
    accept(we, addr, wdata, 1'b0);
    complete(we, addr, wdata, mrd, sw, tag);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int          oe_n, resp_n;
    logic [15:0] resp_d;

    Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; SW = '0;
    r0_reset = 1'b1; r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0;
    r0_req_wdata = '0; r0_mem_rdata = '0; r0_sw = '0;
    m_mdr = '0; m_led = '0;
    step();
    step();
    Reset = 1'b0;
    r0_reset = 1'b0;

    // Reset state.
    check("rst/ready", req_ready, 1'b1);
    check("rst/MAR", MAR, 16'h0);
    check("rst/MDR", MDR, 16'h0);
    check("rst/LED", LED, 10'h0);
    check("rst/oe", mem_oe, 1'b0);
    check("rst/we", mem_we, 1'b0);
    check("rst/resp", resp_valid, 1'b0);

    // Directed: memory read, memory write, IO write, IO read.
    run_txn(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000, "rd40");
    check("rd40/beef", MDR, 16'hBEEF);
    run_txn(1'b1, 16'h0041, 16'h1234, 16'hDEAD, 16'h0000, "wr41");
    check("wr41/led_kept", LED, 10'h000);
    run_txn(1'b1, 16'hFFFF, 16'h03FF, 16'h0000, 16'h0000, "iowr");
    check("iowr/led", LED, 10'h3FF);
    run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h00A5, "iord");
    check("iord/rdata", resp_rdata, 16'h00A5);
    run_txn(1'b1, 16'h0042, 16'hFC00, 16'h0000, 16'h0000, "wr42");
    check("wr42/led_kept", LED, 10'h3FF);

    // req_valid held through a read: one access, next accept after RESP.
    accept(1'b0, 16'h0100, 16'h0000, 1'b1);
    req_addr  = 16'h0200;
    req_we    = 1'b1;
    req_wdata = 16'h5555;
    complete(1'b0, 16'h0100, 16'h0000, 16'h1111, 16'h0000, "hold1");
    step();
    check("hold/idle_ready", req_ready, 1'b1);
    check("hold/mar_kept", MAR, 16'h0100);
    step();
    req_valid = 1'b0;
    check("hold/second_mar", MAR, 16'h0200);
    complete(1'b1, 16'h0200, 16'h5555, 16'h0000, 16'h0000, "hold2");
    step();

    // Reset during the second ACCESS cycle of a read.
    mem_rdata = 16'hCAFE;
    accept(1'b0, 16'h0300, 16'h0000, 1'b0);
    step();
    check("abort/oe_before", mem_oe, 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_mdr = '0;
    m_led = '0;
    check("abort/ready", req_ready, 1'b1);
    check("abort/MDR", MDR, 16'h0);
    check("abort/LED", LED, 10'h0);
    check("abort/oe", mem_oe, 1'b0);
    check("abort/we", mem_we, 1'b0);
    seen = resp_valid;
    for (int i = 0; i < 5; i++) begin
      step();
      seen |= resp_valid;
    end
    check("abort/no_resp", seen, 1'b0);

    // Reset wins over a simultaneous request.
    Reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0400; req_wdata = 16'h7777;
    step();
    Reset = 1'b0; req_valid = 1'b0;
    check("rstprio/MAR", MAR, 16'h0);
    check("rstprio/MDR", MDR, 16'h0);
    check("rstprio/ready", req_ready, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      logic        we;
      logic [15:0] addr;
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      run_txn(we, addr, 16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rnd%0d", t));
    end

    // Zero-wait instance: one-cycle ACCESS, response two cycles after accept.
    r0_mem_rdata = 16'h7777;
    check("w0/ready", r0_req_ready, 1'b1);
    r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 16'h0010;
    step();
    r0_req_valid = 1'b0;
    oe_n = 0; resp_n = 0; resp_d = 'x;
    for (int n = 1; n <= 6 && resp_n == 0; n++) begin
      if (n > 1) step();
      oe_n += int'(r0_mem_oe);
      if (r0_resp_valid) begin
        resp_n = n;
        resp_d = r0_resp_rdata;
      end
    end
    check("w0/oe_cycles", oe_n, 1);
    check("w0/latency", resp_n, 2);
    check("w0/rdata", resp_d, 16'h7777);
    step();
    check("w0/idle", r0_req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_access_unit
